regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (WE3/A3/WD3) between two writeback producers: ALU result and memory-load result.
- Each producer has a small queue with a valid/ready handshake.
- A round-robin arbiter drains the queue heads into a registered write-port stage that drives the RegFile directly.
- Also exports a pending-write mask that hazard logic uses to stall readers of in-flight destinations.

Parameters:
DATA_W, 32, write-data width
ADDR_W, 5, register address width; register count = 2**ADDR_W
QDEPTH, 2, entries per producer queue; power of two, >=2

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
alu_valid  input  1  ALU writeback request
alu_ready  output  1  ALU queue can accept
alu_rd  input  ADDR_W  ALU destination register
alu_wd  input  DATA_W  ALU write data
mem_valid  input  1  load writeback request
mem_ready  output  1  load queue can accept
mem_rd  input  ADDR_W  load destination register
mem_wd  input  DATA_W  load write data
WE3  output  1  register-file write enable (registered)
A3  output  ADDR_W  register-file write address (registered)
WD3  output  DATA_W  register-file write data (registered)
pending  output  2**ADDR_W  bit r = write to r queued or in output stage

Behaviour:
- Reset (asynchronous, rst_n=0): both queues emptied; WE3=0, A3=0, WD3=0; round-robin pointer = ALU-first.
  - alu_ready/mem_ready=1 once queues are empty; pending=0.
  - Reset mid-operation discards all queued writes; none reach WE3.
- Handshake:
  - Transfer occurs when x_valid && x_ready at a clock edge.
  - x_ready = queue not full, based only on the registered occupancy. There is no same-cycle pop bypass, so a full queue holds ready low even while it is being drained that cycle.
  - Producer holds rd/wd stable while valid && !ready.
- x0 filter: an accepted request with rd==0 completes the handshake but is not enqueued. It never produces WE3=1.
- Queues: FIFO per producer; pointer-based, wrap modulo QDEPTH; occupancy counter 0..QDEPTH.
- Arbitration, each cycle:
  - Exactly one head is popped if any queue is non-empty.
  - Only one non-empty queue: that queue wins.
  - Both non-empty: the winner is the one indicated by the pointer; the pointer then flips to the other producer.
  - The pointer changes only on a contested grant.
- Output stage:
  - The popped entry appears on WE3=1/A3/WD3 at the next edge, giving a 1-cycle latency from queue head to write port.
  - No grant that cycle: WE3=0; A3/WD3 hold their previous values.
  - Minimum latency from handshake to WE3=1 is 2 edges.
  - Sustained throughput is one write per cycle total.
- Ordering:
  - FIFO order is preserved within each producer.
  - No ordering is enforced between producers. The issue logic must use `pending` to avoid WAW between ALU and load.
- pending: combinational OR of decoded rd over all valid queue entries plus (A3 when WE3=1).
  - Bit 0 is always 0.
  - A bit clears the cycle after its last write is presented on WE3.
- Simultaneous enqueue and pop on the same queue: occupancy unchanged; both take effect.

Optional Feature:
WB_FIXED_PRIO_EN
- Defined: round-robin is replaced by fixed priority, with the mem queue always winning when non-empty. The pointer register is not implemented. ALU starvation is accepted because loads are infrequent.
- Undefined: round-robin as specified above.

Test Plan:
- Reset with both queues loaded -> WE3=0, A3=0, WD3=0, pending=0, both readys=1 while rst_n low; no write emerges after release.
- Single ALU write rd=5, wd=0x1234_5678 -> WE3=1, A3=5, WD3=0x12345678 exactly 2 edges after handshake, one cycle only; pending[5] high until the cycle after.
- Both valid every cycle: ALU rd=1,2,3 and mem rd=9,10,11 -> WE3 sequence 1,9,2,10,3,11 (ALU first after reset); WB_FIXED_PRIO_EN build -> 9,10,11,1,2,3.
- ALU push of 3 entries with QDEPTH=2 and mem queue also loaded -> alu_ready drops after 2nd accept; 3rd accepted only after a pop; no entry lost or duplicated.
- Write with rd=0, wd=0xFFFF_FFFF -> handshake completes, WE3 stays 0, pending stays 0.
- Ten back-to-back ALU writes with wrap-around of queue pointers -> ten WE3 pulses in issue order, continuous one per cycle after initial latency.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - ALU/load writeback queues arbitrated onto the register-file write port (option macro: WB_FIXED_PRIO_EN)
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int QDEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [ADDR_W-1:0]    alu_rd,
    input  logic [DATA_W-1:0]    alu_wd,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [ADDR_W-1:0]    mem_rd,
    input  logic [DATA_W-1:0]    mem_wd,
    output logic                 WE3,
    output logic [ADDR_W-1:0]    A3,
    output logic [DATA_W-1:0]    WD3,
    output logic [2**ADDR_W-1:0] pending
);
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = $clog2(QDEPTH + 1);

    // Producer index: 0 = ALU, 1 = load
    logic [1:0]        in_valid;
    logic [ADDR_W-1:0] in_rd [2];
    logic [DATA_W-1:0] in_wd [2];
    logic [1:0]        q_ready;
    logic [1:0]        q_ne;
    logic [1:0]        push;
    logic [1:0]        gnt;

    logic [PW-1:0]     wr_ptr_q [2];
    logic [PW-1:0]     wr_ptr_d [2];
    logic [PW-1:0]     rd_ptr_q [2];
    logic [PW-1:0]     rd_ptr_d [2];
    logic [CW-1:0]     count_q  [2];
    logic [CW-1:0]     count_d  [2];
    logic [ADDR_W-1:0] rd_mem_q [2][QDEPTH];
    logic [ADDR_W-1:0] rd_mem_d [2][QDEPTH];
    logic [DATA_W-1:0] wd_mem_q [2][QDEPTH];
    logic [DATA_W-1:0] wd_mem_d [2][QDEPTH];

    logic [2**ADDR_W-1:0] queue_mask;

    logic              we3_q, we3_d;
    logic [ADDR_W-1:0] a3_q, a3_d;
    logic [DATA_W-1:0] wd3_q, wd3_d;

    assign in_valid = {mem_valid, alu_valid};
    assign in_rd[0] = alu_rd;
    assign in_rd[1] = mem_rd;
    assign in_wd[0] = alu_wd;
    assign in_wd[1] = mem_wd;
    assign alu_ready = q_ready[0];
    assign mem_ready = q_ready[1];

    // Handshake: ready from registered occupancy only; x0 writes are accepted but dropped
    always_comb begin
        q_ready = '0;
        q_ne    = '0;
        push    = '0;
        for (int p = 0; p < 2; p++) begin
            q_ready[p] = (count_q[p] != CW'(QDEPTH));
            q_ne[p]    = (count_q[p] != '0);
            push[p]    = in_valid[p] && q_ready[p] && (in_rd[p] != '0);
        end
    end

`ifdef WB_FIXED_PRIO_EN
    // Fixed priority: loads always win when present
    always_comb begin
        gnt    = '0;
        gnt[1] = q_ne[1];
        gnt[0] = q_ne[0] && !q_ne[1];
    end
`else
    logic rr_q, rr_d;

    // Round-robin: rr_q=0 favours ALU on a contest; flips only when both heads compete
    always_comb begin
        gnt    = '0;
        gnt[0] = q_ne[0] && (!q_ne[1] || !rr_q);
        gnt[1] = q_ne[1] && (!q_ne[0] || rr_q);
        rr_d   = rr_q;
        if (q_ne[0] && q_ne[1]) begin
            rr_d = !rr_q;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    // Queue next state: write at tail on push, advance head on grant
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            wr_ptr_d[p] = wr_ptr_q[p];
            rd_ptr_d[p] = rd_ptr_q[p];
            count_d[p]  = count_q[p];
            for (int k = 0; k < QDEPTH; k++) begin
                rd_mem_d[p][k] = rd_mem_q[p][k];
                wd_mem_d[p][k] = wd_mem_q[p][k];
            end
            if (push[p]) begin
                rd_mem_d[p][wr_ptr_q[p]] = in_rd[p];
                wd_mem_d[p][wr_ptr_q[p]] = in_wd[p];
                wr_ptr_d[p] = wr_ptr_q[p] + PW'(1);
            end
            if (gnt[p]) begin
                rd_ptr_d[p] = rd_ptr_q[p] + PW'(1);
            end
            if (push[p] && !gnt[p]) begin
                count_d[p] = count_q[p] + CW'(1);
            end else if (!push[p] && gnt[p]) begin
                count_d[p] = count_q[p] - CW'(1);
            end
        end
    end

    // Queue state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                wr_ptr_q[p] <= '0;
                rd_ptr_q[p] <= '0;
                count_q[p]  <= '0;
                for (int k = 0; k < QDEPTH; k++) begin
                    rd_mem_q[p][k] <= '0;
                    wd_mem_q[p][k] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                wr_ptr_q[p] <= wr_ptr_d[p];
                rd_ptr_q[p] <= rd_ptr_d[p];
                count_q[p]  <= count_d[p];
                for (int k = 0; k < QDEPTH; k++) begin
                    rd_mem_q[p][k] <= rd_mem_d[p][k];
                    wd_mem_q[p][k] <= wd_mem_d[p][k];
                end
            end
        end
    end

    // Write-port stage: present the granted head next cycle, otherwise hold address/data
    always_comb begin
        we3_d = gnt[0] || gnt[1];
        a3_d  = a3_q;
        wd3_d = wd3_q;
        if (gnt[0]) begin
            a3_d  = rd_mem_q[0][rd_ptr_q[0]];
            wd3_d = wd_mem_q[0][rd_ptr_q[0]];
        end else if (gnt[1]) begin
            a3_d  = rd_mem_q[1][rd_ptr_q[1]];
            wd3_d = wd_mem_q[1][rd_ptr_q[1]];
        end
    end

    // Write-port registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we3_q <= 1'b0;
            a3_q  <= '0;
            wd3_q <= '0;
        end else begin
            we3_q <= we3_d;
            a3_q  <= a3_d;
            wd3_q <= wd3_d;
        end
    end

    assign WE3 = we3_q;
    assign A3  = a3_q;
    assign WD3 = wd3_q;

    // Destinations of every occupied queue slot, walked from each head
    always_comb begin
        queue_mask = '0;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < QDEPTH; k++) begin
                if (CW'(k) < count_q[p]) begin
                    queue_mask[rd_mem_q[p][rd_ptr_q[p] + PW'(k)]] = 1'b1;
                end
            end
        end
    end

    // In-flight mask for hazard stalls; x0 is never a real destination
    always_comb begin
        pending = queue_mask;
        if (we3_q) begin
            pending[a3_q] = 1'b1;
        end
        pending[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - table-driven check of regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int QDEPTH = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              alu_valid, alu_ready, mem_valid, mem_ready;
    logic [ADDR_W-1:0] alu_rd, mem_rd;
    logic [DATA_W-1:0] alu_wd, mem_wd;
    logic              WE3;
    logic [ADDR_W-1:0] A3;
    logic [DATA_W-1:0] WD3;
    logic [31:0]       pending;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_wd(alu_wd),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wd(mem_wd),
        .WE3(WE3), .A3(A3), .WD3(WD3), .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ar;
        logic [31:0] aw;
        logic        mv;
        logic [4:0]  mr;
        logic [31:0] mw;
        logic        e_ar;
        logic        e_mr;
        logic        e_we;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
        logic [31:0] e_pend;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input int av, input int ar, input int aw, input int mv, input int mr,
                                input int mw, input int e_ar, input int e_mr, input int e_we,
                                input int e_a3, input int e_wd, input int e_pend);
        vec_t v;
        v.av = 1'(av);   v.ar = 5'(ar);   v.aw = 32'(aw);
        v.mv = 1'(mv);   v.mr = 5'(mr);   v.mw = 32'(mw);
        v.e_ar = 1'(e_ar); v.e_mr = 1'(e_mr); v.e_we = 1'(e_we);
        v.e_a3 = 5'(e_a3); v.e_wd = 32'(e_wd); v.e_pend = 32'(e_pend);
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_rd = '0; alu_wd = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_wd = '0;
    endtask

    task automatic fill();
        // single ALU write rd=5
        vecs.push_back(mk(1, 5, 32'h12345678, 0, 0, 0,  1, 1, 0,  0, 0,            0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,  1, 1, 0,  0, 0,            32'h20));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,  1, 1, 1,  5, 32'h12345678, 32'h20));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,  1, 1, 0,  5, 32'h12345678, 0));
        // both producers every cycle: expect 1,9,2,10,3,11
        vecs.push_back(mk(1, 1, 'hA1, 1,  9, 'hB9,  1, 1, 0,  5, 32'h12345678, 0));
        vecs.push_back(mk(1, 2, 'hA2, 1, 10, 'hBA,  1, 1, 0,  5, 32'h12345678, 'h202));
        vecs.push_back(mk(1, 3, 'hA3, 1, 11, 'hBB,  1, 0, 1,  1, 'hA1, 'h606));
        vecs.push_back(mk(0, 0, 0,    1, 11, 'hBB,  0, 1, 1,  9, 'hB9, 'h60C));
        vecs.push_back(mk(0, 0, 0,    0,  0, 0,     1, 0, 1,  2, 'hA2, 'hC0C));
        vecs.push_back(mk(0, 0, 0,    0,  0, 0,     1, 1, 1, 10, 'hBA, 'hC08));
        vecs.push_back(mk(0, 0, 0,    0,  0, 0,     1, 1, 1,  3, 'hA3, 'h808));
        vecs.push_back(mk(0, 0, 0,    0,  0, 0,     1, 1, 1, 11, 'hBB, 'h800));
        vecs.push_back(mk(0, 0, 0,    0,  0, 0,     1, 1, 0, 11, 'hBB, 0));
        // three ALU pushes into a depth-2 queue with load traffic; pointer now favours mem
        vecs.push_back(mk(1, 12, 'hC0, 1, 20, 'hD0,  1, 1, 0, 11, 'hBB, 0));
        vecs.push_back(mk(1, 13, 'hC1, 1, 21, 'hD1,  1, 1, 0, 11, 'hBB, 'h101000));
        vecs.push_back(mk(1, 14, 'hC2, 0,  0, 0,     0, 1, 1, 20, 'hD0, 'h303000));
        vecs.push_back(mk(1, 14, 'hC2, 0,  0, 0,     1, 1, 1, 12, 'hC0, 'h203000));
        vecs.push_back(mk(0,  0, 0,    0,  0, 0,     0, 1, 1, 21, 'hD1, 'h206000));
        vecs.push_back(mk(0,  0, 0,    0,  0, 0,     1, 1, 1, 13, 'hC1, 'h6000));
        vecs.push_back(mk(0,  0, 0,    0,  0, 0,     1, 1, 1, 14, 'hC2, 'h4000));
        vecs.push_back(mk(0,  0, 0,    0,  0, 0,     1, 1, 0, 14, 'hC2, 0));
        // rd=0 writes from both producers are swallowed
        vecs.push_back(mk(1, 0, 32'hFFFFFFFF, 1, 0, 32'hFFFFFFFF,  1, 1, 0, 14, 'hC2, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,             1, 1, 0, 14, 'hC2, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,             1, 1, 0, 14, 'hC2, 0));
    endtask

    task automatic check_reset_state(input int idx);
        chk("rst_we3", idx, 32'(WE3), 0);
        chk("rst_a3", idx, 32'(A3), 0);
        chk("rst_wd3", idx, WD3, 0);
        chk("rst_pending", idx, pending, 0);
        chk("rst_alu_ready", idx, 32'(alu_ready), 1);
        chk("rst_mem_ready", idx, 32'(mem_ready), 1);
    endtask

    initial begin
        fill();
        rst_n = 1'b0;
        idle();
        alu_valid = 1'b1; alu_rd = 5'd7; alu_wd = 32'h77;
        mem_valid = 1'b1; mem_rd = 5'd8; mem_wd = 32'h88;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state(0);
        @(negedge clk);
        idle();
        rst_n = 1'b1;

        // table-driven vectors: drive, compare pre-edge outputs, clock
        for (int i = 0; i < vecs.size(); i++) begin
            alu_valid = vecs[i].av; alu_rd = vecs[i].ar; alu_wd = vecs[i].aw;
            mem_valid = vecs[i].mv; mem_rd = vecs[i].mr; mem_wd = vecs[i].mw;
            #1;
            chk("alu_ready", i, 32'(alu_ready), 32'(vecs[i].e_ar));
            chk("mem_ready", i, 32'(mem_ready), 32'(vecs[i].e_mr));
            chk("we3", i, 32'(WE3), 32'(vecs[i].e_we));
            chk("a3", i, 32'(A3), 32'(vecs[i].e_a3));
            chk("wd3", i, WD3, vecs[i].e_wd);
            chk("pending", i, pending, vecs[i].e_pend);
            @(posedge clk);
            #1;
        end
        idle();

        // ten back-to-back ALU writes through the wrapping queue
        for (int c = 0; c < 13; c++) begin
            alu_valid = (c < 10);
            alu_rd    = 5'(c + 1);
            alu_wd    = 32'h100 + 32'(c);
            #1;
            chk("b2b_alu_ready", c, 32'(alu_ready), 1);
            chk("b2b_we3", c, 32'(WE3), (c >= 2 && c <= 11) ? 1 : 0);
            if (c >= 2 && c <= 11) begin
                chk("b2b_a3", c, 32'(A3), 32'(c - 1));
                chk("b2b_wd3", c, WD3, 32'h100 + 32'(c - 2));
            end
            @(posedge clk);
            #1;
        end
        idle();

        // reset while both producers have queued writes
        alu_valid = 1'b1; alu_rd = 5'd4; alu_wd = 32'h44;
        mem_valid = 1'b1; mem_rd = 5'd6; mem_wd = 32'h66;
        @(posedge clk);
        #1;
        idle();
        chk("mid_pending", 0, pending, 32'h50);
        @(posedge clk);
        #1;
        chk("mid_we3", 0, 32'(WE3), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state(1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            chk("post_rst_we3", c, 32'(WE3), 0);
            chk("post_rst_pending", c, pending, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
